// File: rtl/slotmaker_card_table_pkg.sv
// Shared widths, card ID encodings and FSM states for the slot-to-card table.
// Firmware headers and the card emulators use the same card ID values.
package slotmaker_pkg;

    localparam int SLOT_BITS  = 3;
    localparam int CARD_BITS  = 8;
    localparam int NUM_SLOTS  = 8;
    localparam int TIMER_BITS = 8;

    typedef logic [CARD_BITS-1:0] card_id_t;

    localparam card_id_t CARD_NONE = 8'h00;

    typedef enum card_id_t {
        CARD_DISK_II       = 8'h01,
        CARD_MOCKINGBOARD  = 8'h02,
        CARD_SUPER_SERIAL  = 8'h03,
        CARD_RAMWORKS      = 8'h04,
        CARD_MOUSE         = 8'h05,
        CARD_CLOCK         = 8'h06
    } card_kind_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } tbl_state_e;

endpackage

// File: rtl/slotmaker_card_table_if.sv
// Firmware-side configuration port: slot address, write data/strobe and read-back data.
interface slotmaker_config_if;
    import slotmaker_pkg::*;

    logic [SLOT_BITS-1:0] slot;
    card_id_t             card_i;
    logic                 wr;
    card_id_t             card_o;

    modport master (output slot, output card_i, output wr, input  card_o);
    modport slave  (input  slot, input  card_i, input  wr, output card_o);
endinterface

// File: rtl/slotmaker_card_table_timer.sv
// Per-slot card reset timer: down counter that is active while non-zero.
// A load while still running restarts the count, so pulses only ever extend.
module slot_reset_timer
    import slotmaker_pkg::*;
#(
    parameter logic [TIMER_BITS-1:0] LOAD_VAL = 8'd16
) (
    input  logic clk,
    input  logic resetn,
    input  logic load_i,
    output logic active_o
);

    logic [TIMER_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = LOAD_VAL;
        else if (count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign active_o = (count_q != '0);

endmodule

// File: rtl/slotmaker_card_table.sv
// Slot-to-card assignment table with firmware read/write port, power-up global
// card reset, and a timed per-slot reset whenever a slot's card changes.
module slotmaker_card_table
    import slotmaker_pkg::*;
#(
    parameter int unsigned                    RESET_CYCLES  = 16,
    parameter logic [NUM_SLOTS*CARD_BITS-1:0] DEFAULT_CARDS = '0
) (
    input  logic                                clk,
    input  logic                                resetn,
    slotmaker_config_if.slave                   cfg,
    output logic [NUM_SLOTS-1:0][CARD_BITS-1:0] slot_card_o,
    output logic [NUM_SLOTS-1:0]                slot_reset_o,
    output logic                                init_done_o,
    output logic                                change_o
);

    localparam logic [TIMER_BITS-1:0] RST_LEN  = TIMER_BITS'(RESET_CYCLES);
    localparam logic [TIMER_BITS-1:0] INIT_END = TIMER_BITS'(RESET_CYCLES - 1);

    tbl_state_e                          state_q, state_d;
    logic [TIMER_BITS-1:0]               init_cnt_q, init_cnt_d;
    logic [NUM_SLOTS-1:0][CARD_BITS-1:0] table_q;
    logic                                change_q;
    logic                                wr_diff;
    logic [NUM_SLOTS-1:0]                timer_load;
    logic [NUM_SLOTS-1:0]                timer_act;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_END)
                    state_d = ST_RUN;
                else
                    init_cnt_d = init_cnt_q + 1'b1;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Only a write that actually changes the slot's card counts as a change.
    assign wr_diff = cfg.wr && (cfg.card_i != table_q[cfg.slot]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            table_q  <= DEFAULT_CARDS;
            change_q <= 1'b0;
        end else begin
            if (wr_diff)
                table_q[cfg.slot] <= cfg.card_i;
            change_q <= wr_diff;
        end
    end

    // Zero-latency read-back: the controller samples this in its ready cycle.
    assign cfg.card_o = table_q[cfg.slot];

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        // During INIT the global reset already covers every slot.
        assign timer_load[g] = wr_diff && (state_q == ST_RUN) && (cfg.slot == SLOT_BITS'(g));

        slot_reset_timer #(
            .LOAD_VAL (RST_LEN)
        ) u_timer (
            .clk      (clk),
            .resetn   (resetn),
            .load_i   (timer_load[g]),
            .active_o (timer_act[g])
        );
    end

    assign slot_card_o  = table_q;
    assign slot_reset_o = timer_act | {NUM_SLOTS{state_q == ST_INIT}};
    assign init_done_o  = (state_q == ST_RUN);
    assign change_o     = change_q;

endmodule

// File: tb/tb_slotmaker_card_table.sv
// Directed bench for slotmaker_card_table: expectations are queued on a scoreboard
// and popped against the DUT outputs, sampled on the falling clock edge.
module tb_slotmaker_card_table;
    import slotmaker_pkg::*;

    localparam logic [63:0] DEF = 64'h0706050403020100;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic [7:0][7:0]     slot_card;
    logic [7:0]          slot_reset;
    logic                init_done;
    logic                change;

    slotmaker_config_if cfg_if();

    slotmaker_card_table #(
        .RESET_CYCLES  (16),
        .DEFAULT_CARDS (DEF)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cfg          (cfg_if),
        .slot_card_o  (slot_card),
        .slot_reset_o (slot_reset),
        .init_done_o  (init_done),
        .change_o     (change)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] mdl [8];

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [63:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_mis++;
            $error("FAIL sb_empty: observed %0h required <entry>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_mis++;
            $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] v);
        push(tag, v);
        pop_cmp(obs);
    endtask

    function automatic logic [63:0] mdl_flat();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = mdl[i];
        return r;
    endfunction

    task automatic mdl_reset();
        logic [63:0] d;
        d = DEF;
        for (int i = 0; i < 8; i++) mdl[i] = d[i*8 +: 8];
    endtask

    // Counts consecutive high samples of slot_reset[b], starting with the current one.
    task automatic pulse_len(input int b, output int len);
        len = 0;
        while (slot_reset[b] === 1'b1 && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic drive_wr(input int s, input logic [7:0] c);
        cfg_if.slot   = 3'(s);
        cfg_if.card_i = c;
        cfg_if.wr     = 1'b1;
    endtask

    initial begin
        int len;
        int cnt;
        cfg_if.slot   = '0;
        cfg_if.card_i = '0;
        cfg_if.wr     = 1'b0;
        mdl_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_slot_reset", 64'(slot_reset), 64'hFF);
        check("rst_init_done",  64'(init_done),  64'h0);
        check("rst_change",     64'(change),     64'h0);
        check("rst_table",      slot_card,       mdl_flat());

        // 1: global reset spans 16 cycles after release
        resetn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (slot_reset === 8'hFF && init_done === 1'b0) cnt++;
            @(negedge clk);
        end
        check("init_high_cycles", 64'(cnt),        64'd16);
        check("init_end_reset",   64'(slot_reset), 64'h00);
        check("init_done",        64'(init_done),  64'h1);
        cfg_if.slot = 3'd5;
        #1;
        check("read_slot5", 64'(cfg_if.card_o), 64'h05);

        // 2: effective write to slot 3
        @(negedge clk);
        drive_wr(3, 8'h2A);
        push("wr_cycle_read", {56'h0, mdl[3]});
        #1;
        pop_cmp(64'(cfg_if.card_o));
        mdl[3] = 8'h2A;
        @(negedge clk);
        cfg_if.wr = 1'b0;
        check("post_wr_read",  64'(cfg_if.card_o), 64'h2A);
        check("wr3_change",    64'(change),        64'h1);
        check("wr3_reset",     64'(slot_reset),    64'h08);
        check("wr3_table",     slot_card,          mdl_flat());
        @(negedge clk);
        check("wr3_change_1shot", 64'(change), 64'h0);
        pulse_len(3, len);
        check("wr3_pulse_len", 64'(len + 1), 64'd16);
        check("wr3_pulse_end", 64'(slot_reset), 64'h00);

        // 3: rewrite of the same value is a no-op
        drive_wr(3, 8'h2A);
        @(negedge clk);
        cfg_if.wr = 1'b0;
        check("same_change", 64'(change),     64'h0);
        check("same_reset",  64'(slot_reset), 64'h00);
        @(negedge clk);
        check("same_reset2", 64'(slot_reset), 64'h00);

        // 4: second write 10 cycles later extends slot 2 pulse to 26 cycles
        drive_wr(2, 8'h11);
        mdl[2] = 8'h11;
        cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (slot_reset[2] === 1'b1) cnt++;
            if (i == 1) cfg_if.wr = 1'b0;
            if (i == 10) drive_wr(2, 8'h12);
        end
        mdl[2] = 8'h12;
        @(negedge clk);
        cfg_if.wr = 1'b0;
        check("ext_change", 64'(change), 64'h1);
        check("ext_read",   64'(cfg_if.card_o), 64'h12);
        pulse_len(2, len);
        check("ext_pulse_len", 64'(cnt + len), 64'd26);
        check("ext_table",     slot_card, mdl_flat());

        // 5: write during INIT updates table but adds no pulse
        resetn = 1'b0;
        mdl_reset();
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        drive_wr(1, 8'h33);
        mdl[1] = 8'h33;
        @(negedge clk);
        cfg_if.wr = 1'b0;
        check("init_wr_change", 64'(change),     64'h1);
        check("init_wr_table",  slot_card,       mdl_flat());
        check("init_wr_reset",  64'(slot_reset), 64'hFF);
        pulse_len(1, len);
        check("init_wr_len",    64'(len),        64'd12);
        check("init_wr_end",    64'(slot_reset), 64'h00);
        check("init_wr_done",   64'(init_done),  64'h1);
        @(negedge clk);
        cfg_if.slot = 3'd1;
        #1;
        check("init_wr_noextra", 64'(slot_reset),    64'h00);
        check("init_wr_read",    64'(cfg_if.card_o), 64'h33);

        // 6: asynchronous reset in the middle of a slot 6 pulse
        @(negedge clk);
        drive_wr(6, 8'h99);
        mdl[6] = 8'h99;
        @(negedge clk);
        cfg_if.wr = 1'b0;
        check("s6_reset", 64'(slot_reset), 64'h40);
        check("s6_change", 64'(change), 64'h1);
        #2;
        resetn = 1'b0;
        mdl_reset();
        #1;
        check("arst_slot_reset", 64'(slot_reset), 64'hFF);
        check("arst_init_done",  64'(init_done),  64'h0);
        check("arst_change",     64'(change),     64'h0);
        check("arst_table",      slot_card,       mdl_flat());
        cfg_if.slot = 3'd6;
        #1;
        check("arst_read6", 64'(cfg_if.card_o), 64'h06);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
